// File: rtl/pwm_multi_ramp.sv
// CH-channel PWM sharing one period counter. Each channel runs fixed, sawtooth or triangle duty;
// duty/mode/step/period writes are shadowed and only take effect on a period boundary.
module pwm_multi_ramp #(
    parameter int unsigned CH         = 4,
    parameter int unsigned W          = 8,
    parameter int unsigned PERIOD_RST = 99,
    localparam int unsigned CW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_duty,
    input  logic [1:0]    cfg_mode,
    input  logic [W-1:0]  cfg_step,
    input  logic          per_we,
    input  logic [W-1:0]  per_val,
    output logic [CH-1:0] pwm,
    output logic          cyc_done
);
    localparam int unsigned LW = W + 1;

    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_per_act;
    logic [W-1:0]  r_per_shd;
    logic          r_per_pend;
    logic [W-1:0]  r_duty_shd [CH];
    logic [W-1:0]  r_step_shd [CH];
    logic [1:0]    r_mode_shd [CH];
    logic [LW-1:0] r_duty_act [CH];
    logic [W-1:0]  r_step_act [CH];
    logic [1:0]    r_mode_act [CH];
    logic [CH-1:0] r_pend;
    logic [CH-1:0] r_dir_dn;
    logic [CH-1:0] r_pwm;
    logic          r_cyc_done;

    logic          w_bound;
    logic          w_commit;
    logic [LW-1:0] w_lim;
    logic [CH-1:0] w_wr_sel;
    logic [LW-1:0] w_sum     [CH];
    logic [LW-1:0] w_duty_nx [CH];
    logic [CH-1:0] w_dir_nx;

    assign w_bound  = en && (r_cnt == r_per_act);
    // With the counter stopped there is no period to protect, so commit every clock.
    assign w_commit = w_bound || !en;
    assign w_lim    = {1'b0, r_per_act} + LW'(1);
    assign pwm      = r_pwm;
    assign cyc_done = r_cyc_done;

    always_comb begin
        w_dir_nx = r_dir_dn;
        for (int i = 0; i < CH; i++) begin
            w_wr_sel[i]  = cfg_we && (32'(cfg_ch) == 32'(i));
            w_sum[i]     = r_duty_act[i] + {1'b0, r_step_act[i]};
            w_duty_nx[i] = r_duty_act[i];
            if (r_step_act[i] != '0) begin
                case (r_mode_act[i])
                    2'b01: w_duty_nx[i] = (w_sum[i] > w_lim) ? '0 : w_sum[i];
                    2'b10: begin
                        if (!r_dir_dn[i]) begin
                            if (w_sum[i] >= w_lim) begin
                                w_duty_nx[i] = w_lim;
                                w_dir_nx[i]  = 1'b1;
                            end else begin
                                w_duty_nx[i] = w_sum[i];
                            end
                        end else if (r_duty_act[i] <= {1'b0, r_step_act[i]}) begin
                            w_duty_nx[i] = '0;
                            w_dir_nx[i]  = 1'b0;
                        end else begin
                            w_duty_nx[i] = r_duty_act[i] - {1'b0, r_step_act[i]};
                        end
                    end
                    default: w_duty_nx[i] = r_duty_act[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_per_act  <= W'(PERIOD_RST);
            r_per_shd  <= '0;
            r_per_pend <= 1'b0;
            r_pend     <= '0;
            r_dir_dn   <= '0;
            r_pwm      <= '0;
            r_cyc_done <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_duty_shd[i] <= '0;
                r_step_shd[i] <= '0;
                r_mode_shd[i] <= '0;
                r_duty_act[i] <= '0;
                r_step_act[i] <= '0;
                r_mode_act[i] <= '0;
            end
        end else begin
            r_cnt      <= (!en || w_bound) ? '0 : r_cnt + W'(1);
            r_cyc_done <= w_bound;

            if (w_commit && r_per_pend) r_per_act <= r_per_shd;
            if (per_we) begin
                r_per_shd  <= per_val;
                r_per_pend <= 1'b1;
            end else if (w_commit) begin
                r_per_pend <= 1'b0;
            end

            for (int i = 0; i < CH; i++) begin
                r_pwm[i] <= en && ({1'b0, r_cnt} < r_duty_act[i]);
                // A pending commit overrides the ramp step on the same boundary.
                if (w_commit && r_pend[i]) begin
                    r_duty_act[i] <= {1'b0, r_duty_shd[i]};
                    r_step_act[i] <= r_step_shd[i];
                    r_mode_act[i] <= r_mode_shd[i];
                    r_dir_dn[i]   <= 1'b0;
                end else if (w_bound) begin
                    r_duty_act[i] <= w_duty_nx[i];
                    r_dir_dn[i]   <= w_dir_nx[i];
                end
                if (w_wr_sel[i]) begin
                    r_duty_shd[i] <= cfg_duty;
                    r_step_shd[i] <= cfg_step;
                    r_mode_shd[i] <= cfg_mode;
                    r_pend[i]     <= 1'b1;
                end else if (w_commit) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Directed bench for pwm_multi_ramp: per-period high-clock counts and period lengths are
// checked against a scoreboard of expectations built from the intended duty sequences.
module tb_pwm_multi_ramp;
    logic       clk = 1'b0;
    logic       rst, en, cfg_we, per_we;
    logic [1:0] cfg_ch, cfg_mode;
    logic [7:0] cfg_duty, cfg_step, per_val;
    logic [3:0] pwm;
    logic       cyc_done;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   hi_cnt[4];
    int   len_cnt;

    // Optional write injected during the next measured period.
    int         wr_at = -1;
    bit         wr_per = 1'b0;
    logic [7:0] wr_pval = '0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_duty = '0;
    logic [1:0] wr_mode = '0;
    logic [7:0] wr_step = '0;

    always #5 clk = ~clk;

    pwm_multi_ramp #(.CH(4), .W(8), .PERIOD_RST(99)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_duty (cfg_duty),
        .cfg_mode (cfg_mode),
        .cfg_step (cfg_step),
        .per_we   (per_we),
        .per_val  (per_val),
        .pwm      (pwm),
        .cyc_done (cyc_done)
    );

    function automatic int saw_exp(input int p);
        int t[3] = '{0, 4, 8};
        return t[p % 3];
    endfunction

    function automatic int tri_exp(input int p);
        int t[8] = '{0, 3, 6, 9, 10, 7, 4, 1};
        return t[p % 8];
    endfunction

    task automatic push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "scoreboard_empty";
            e.val = -999;
        end else begin
            e = sb.pop_front();
        end
        n_chk++;
        assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic drive_cfg(input logic [1:0] ch, input logic [7:0] duty,
                             input logic [1:0] mode, input logic [7:0] step);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_duty = duty;
        cfg_mode = mode;
        cfg_step = step;
    endtask

    // Counts samples from just after one cyc_done up to and including the next one.
    task automatic meas();
        len_cnt = -1;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == wr_at) begin
                if (wr_per) begin
                    per_we  = 1'b1;
                    per_val = wr_pval;
                end else begin
                    drive_cfg(wr_ch, wr_duty, wr_mode, wr_step);
                end
            end
            @(negedge clk);
            cfg_we = 1'b0;
            per_we = 1'b0;
            for (int c = 0; c < 4; c++) hi_cnt[c] += (pwm[c] === 1'b1) ? 1 : 0;
            if (cyc_done === 1'b1) begin
                len_cnt = i + 1;
                break;
            end
        end
        wr_at  = -1;
        wr_per = 1'b0;
        pop_chk(len_cnt);
        for (int c = 0; c < 4; c++) pop_chk(hi_cnt[c]);
    endtask

    task automatic period_exp(input int p, input int l, input int e0, input int e1,
                              input int e2, input int e3);
        push($sformatf("p%0d_len", p), l);
        push($sformatf("p%0d_ch0", p), e0);
        push($sformatf("p%0d_ch1", p), e1);
        push($sformatf("p%0d_ch2", p), e2);
        push($sformatf("p%0d_ch3", p), e3);
        meas();
    endtask

    task automatic period(input int p, input int e0, input int e1);
        period_exp(p, 10, e0, e1, saw_exp(p), tri_exp(p));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; per_we = 1'b0;
        cfg_ch = '0; cfg_duty = '0; cfg_mode = '0; cfg_step = '0; per_val = '0;
        repeat (3) @(negedge clk);
        push("rst_pwm", 0);
        push("rst_cyc_done", 0);
        pop_chk(int'(pwm));
        pop_chk(int'(cyc_done));
        rst = 1'b0;

        // Configure with en=0 so each write commits on the following clock.
        per_we = 1'b1; per_val = 8'd9;
        @(negedge clk);
        per_we = 1'b0;
        drive_cfg(2'd0, 8'd3, 2'b00, 8'd0); @(negedge clk);
        drive_cfg(2'd1, 8'd2, 2'b00, 8'd0); @(negedge clk);
        drive_cfg(2'd2, 8'd0, 2'b01, 8'd4); @(negedge clk);
        drive_cfg(2'd3, 8'd0, 2'b10, 8'd3); @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        en = 1'b1;

        for (int p = 0; p <= 10; p++) period(p, 3, 2);

        // Mid-period write at cnt=4 only shows up in the following period.
        wr_at = 4; wr_ch = 2'd1; wr_duty = 8'd7; wr_mode = 2'b00; wr_step = 8'd0;
        period(11, 3, 2);
        period(12, 3, 7);

        // Write on the boundary clock stays pending for one more period.
        wr_at = 9; wr_ch = 2'd0; wr_duty = 8'd5;
        period(13, 3, 7);
        period(14, 3, 7);

        wr_at = 1; wr_ch = 2'd0; wr_duty = 8'd0;
        period(15, 5, 7);
        wr_at = 1; wr_ch = 2'd1; wr_duty = 8'd200;
        period(16, 0, 7);
        period(17, 0, 10);

        en = 1'b0;
        @(negedge clk);
        push("en0_pwm", 0);
        push("en0_cyc_done", 0);
        pop_chk(int'(pwm));
        pop_chk(int'(cyc_done));
        drive_cfg(2'd0, 8'd4, 2'b00, 8'd0);
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        push("en0_pwm_hold", 0);
        pop_chk(int'(pwm));
        en = 1'b1;
        period(18, 4, 10);

        // Reset at cnt=5 with ramps running and a pending write on ch0.
        drive_cfg(2'd0, 8'd8, 2'b00, 8'd0);
        @(negedge clk);
        cfg_we = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push("midrst_pwm", 0);
        push("midrst_cyc_done", 0);
        pop_chk(int'(pwm));
        pop_chk(int'(cyc_done));
        rst = 1'b0;

        wr_at = 10; wr_per = 1'b1; wr_pval = 8'd4;
        period_exp(19, 100, 0, 0, 0, 0);
        wr_at = 0; wr_ch = 2'd3; wr_duty = 8'd200; wr_mode = 2'b00; wr_step = 8'd0;
        period_exp(20, 5, 0, 0, 0, 0);
        period_exp(21, 5, 0, 0, 0, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
